// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: holds the EX/MEM and MEM/WB slots, forwards to ALU operands.
// Latency: operand forwarding and stall are combinational; writeback is 2 cycles after EX.
// Backpressure: stall freezes PC/IF/ID/ID-EX and inserts one bubble into EX/MEM per load-use.
module fwd_hazard_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [ADDR_W-1:0] ex_dest,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              uses_rs,
  input  logic              uses_rt,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic              stall,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  fwd_count,
  output logic [CNT_W-1:0]  stall_count
);

  // EX/MEM slot (S1)
  logic              v1_q, ld1_q;
  logic [ADDR_W-1:0] d1_q;
  logic [DATA_W-1:0] r1_q;
  logic              v1_d, ld1_d;
  logic [ADDR_W-1:0] d1_d;
  logic [DATA_W-1:0] r1_d;

  // MEM/WB slot (S2)
  logic              v2_q;
  logic [ADDR_W-1:0] d2_q;
  logic [DATA_W-1:0] r2_q;
  logic [DATA_W-1:0] r2_d;

  // Saturating performance counters
  logic [CNT_W-1:0]  fwd_cnt_q, stall_cnt_q;

  // Per-operand match and select terms
  logic hit1_rs, hit2_rs, hit1_rt, hit2_rt;
  logic sel1_rs, sel2_rs, sel1_rt, sel2_rt;
  logic stall_rs, stall_rt;
  logic any_fwd;

  // Slot matches; a nonzero source register matching implies a nonzero destination
  always_comb begin
    hit1_rs  = uses_rs & v1_q & (d1_q == rs) & (rs != '0);
    hit2_rs  = uses_rs & v2_q & (d2_q == rs) & (rs != '0);
    hit1_rt  = uses_rt & v1_q & (d1_q == rt) & (rt != '0);
    hit2_rt  = uses_rt & v2_q & (d2_q == rt) & (rt != '0);
    // A load in S1 has no data yet: no S1 forward, and it also masks any older S2 value
    sel1_rs  = hit1_rs & ~ld1_q;
    sel2_rs  = hit2_rs & ~hit1_rs;
    sel1_rt  = hit1_rt & ~ld1_q;
    sel2_rt  = hit2_rt & ~hit1_rt;
    stall_rs = hit1_rs & ld1_q;
    stall_rt = hit1_rt & ld1_q;
    stall    = stall_rs | stall_rt;
    any_fwd  = sel1_rs | sel2_rs | sel1_rt | sel2_rt;
  end

  // Operand muxes: youngest writer (S1) first, then S2, then the register file
  always_comb begin
    data_out1 = data_in1;
    data_out2 = data_in2;
    if (sel1_rs)      data_out1 = r1_q;
    else if (sel2_rs) data_out1 = r2_q;
    if (sel1_rt)      data_out2 = r1_q;
    else if (sel2_rt) data_out2 = r2_q;
  end

  // Next-state for S1 (bubble on stall or flush, keeping d1/r1) and S2 result selection
  always_comb begin
    v1_d  = ex_valid & ex_reg_write;
    ld1_d = ex_valid & ex_mem_read & ex_reg_write;
    d1_d  = ex_dest;
    r1_d  = ex_result;
    if (stall | flush) begin
      v1_d  = 1'b0;
      ld1_d = 1'b0;
      d1_d  = d1_q;
      r1_d  = r1_q;
    end
    r2_d = ld1_q ? mem_load_data : r1_q;
  end

  // Pipeline slot registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q  <= 1'b0;
      ld1_q <= 1'b0;
      d1_q  <= '0;
      r1_q  <= '0;
      v2_q  <= 1'b0;
      d2_q  <= '0;
      r2_q  <= '0;
    end else begin
      v1_q  <= v1_d;
      ld1_q <= ld1_d;
      d1_q  <= d1_d;
      r1_q  <= r1_d;
      v2_q  <= v1_q;
      d2_q  <= d1_q;
      r2_q  <= r2_d;
    end
  end

  // Saturating counters; a stalled cycle never counts as a forward
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (any_fwd && !stall && (fwd_cnt_q != '1))
        fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Writeback port straight from the S2 register; $0 is never written
  always_comb begin
    wb_we       = v2_q & (d2_q != '0);
    wb_addr     = d2_q;
    wb_data     = r2_q;
    fwd_count   = fwd_cnt_q;
    stall_count = stall_cnt_q;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        flush, ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_dest, rs, rt;
  logic [31:0] ex_result, mem_load_data, data_in1, data_in2;
  logic        uses_rs, uses_rt;
  logic [31:0] data_out1, data_out2, wb_data;
  logic        stall, wb_we;
  logic [4:0]  wb_addr;
  logic [15:0] fwd_count, stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .ex_result(ex_result), .mem_load_data(mem_load_data), .rs(rs), .rt(rt),
    .uses_rs(uses_rs), .uses_rt(uses_rt), .data_in1(data_in1), .data_in2(data_in2),
    .data_out1(data_out1), .data_out2(data_out2), .stall(stall), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .fwd_count(fwd_count), .stall_count(stall_count)
  );

  task automatic idle_inputs();
    flush = 0; ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0;
    ex_dest = 0; ex_result = 0; mem_load_data = 0;
    rs = 0; rt = 0; uses_rs = 0; uses_rt = 0;
    data_in1 = 0; data_in2 = 0;
  endtask

  // Advance one rising edge and step 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b1;
    #1;
    reset_n = 1'b0;
    #2;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    data_in1 = 32'h11; data_in2 = 32'h22;
    reset_n = 1'b1;
    #1;
    reset_n = 1'b0;
    #2;
    checks++; if (data_out1 !== 32'h11) begin errors++; $display("FAIL reset_out1: got %h want %h", data_out1, 32'h11); end
    checks++; if (data_out2 !== 32'h22) begin errors++; $display("FAIL reset_out2: got %h want %h", data_out2, 32'h22); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we: got %b want 0", wb_we); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (fwd_count !== 16'd0) begin errors++; $display("FAIL reset_fwd_count: got %0d want 0", fwd_count); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall_count: got %0d want 0", stall_count); end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_exmem_forward();
    do_reset();
    ex_valid = 1; ex_reg_write = 1; ex_dest = 3; ex_result = 32'hAA;
    tick();
    idle_inputs();
    rs = 3; rt = 3; uses_rs = 1; uses_rt = 1;
    #1;
    checks++; if (data_out1 !== 32'hAA) begin errors++; $display("FAIL exmem_out1: got %h want %h", data_out1, 32'hAA); end
    checks++; if (data_out2 !== 32'hAA) begin errors++; $display("FAIL exmem_out2_same_reg: got %h want %h", data_out2, 32'hAA); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL exmem_stall: got %b want 0", stall); end
    tick();
    uses_rs = 0; uses_rt = 0;
    #1;
    checks++; if (fwd_count !== 16'd1) begin errors++; $display("FAIL exmem_fwd_count: got %0d want 1", fwd_count); end
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL exmem_wb_we: got %b want 1", wb_we); end
    checks++; if (wb_addr !== 5'd3) begin errors++; $display("FAIL exmem_wb_addr: got %0d want 3", wb_addr); end
    checks++; if (wb_data !== 32'hAA) begin errors++; $display("FAIL exmem_wb_data: got %h want %h", wb_data, 32'hAA); end
  endtask

  task automatic test_priority();
    do_reset();
    ex_valid = 1; ex_reg_write = 1; ex_dest = 5; ex_result = 32'h1;
    tick();
    ex_result = 32'h2;
    tick();
    idle_inputs();
    rt = 5; uses_rt = 1; data_in2 = 32'hF0;
    #1;
    checks++; if (data_out2 !== 32'h2) begin errors++; $display("FAIL priority_s1_wins: got %h want %h", data_out2, 32'h2); end
    tick();
    #1;
    checks++; if (data_out2 !== 32'h2) begin errors++; $display("FAIL priority_s2_only: got %h want %h", data_out2, 32'h2); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_dest = 7; ex_result = 32'h100;
    tick();
    idle_inputs();
    rs = 7; uses_rs = 1; data_in1 = 32'h77; mem_load_data = 32'hDEADBEEF;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %b want 1", stall); end
    checks++; if (data_out1 !== 32'h77) begin errors++; $display("FAIL loaduse_stale_out1: got %h want %h", data_out1, 32'h77); end
    tick();
    mem_load_data = 32'h0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL loaduse_stall_clear: got %b want 0", stall); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL loaduse_stall_count: got %0d want 1", stall_count); end
    checks++; if (fwd_count !== 16'd0) begin errors++; $display("FAIL loaduse_no_fwd_count: got %0d want 0", fwd_count); end
    checks++; if (data_out1 !== 32'hDEADBEEF) begin errors++; $display("FAIL loaduse_out1: got %h want %h", data_out1, 32'hDEADBEEF); end
    tick();
    uses_rs = 0;
    #1;
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL loaduse_stall_count_hold: got %0d want 1", stall_count); end
    checks++; if (fwd_count !== 16'd1) begin errors++; $display("FAIL loaduse_fwd_count: got %0d want 1", fwd_count); end
  endtask

  task automatic test_zero_and_unused();
    do_reset();
    ex_valid = 1; ex_reg_write = 1; ex_dest = 0; ex_result = 32'h55;
    tick();
    idle_inputs();
    rs = 0; uses_rs = 1; data_in1 = 32'h10;
    #1;
    checks++; if (data_out1 !== 32'h10) begin errors++; $display("FAIL zero_no_fwd: got %h want %h", data_out1, 32'h10); end
    tick();
    #1;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL zero_wb_we: got %b want 0", wb_we); end
    checks++; if (data_out1 !== 32'h10) begin errors++; $display("FAIL zero_no_fwd_s2: got %h want %h", data_out1, 32'h10); end
    idle_inputs();
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_dest = 4; ex_result = 32'h200;
    tick();
    idle_inputs();
    rt = 4; uses_rt = 0; data_in2 = 32'h44;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_no_stall: got %b want 0", stall); end
    checks++; if (data_out2 !== 32'h44) begin errors++; $display("FAIL unused_no_fwd: got %h want %h", data_out2, 32'h44); end
    tick();
    #1;
    checks++; if (fwd_count !== 16'd0) begin errors++; $display("FAIL zero_fwd_count: got %0d want 0", fwd_count); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL zero_stall_count: got %0d want 0", stall_count); end
  endtask

  task automatic test_flush();
    do_reset();
    flush = 1; ex_valid = 1; ex_reg_write = 1; ex_dest = 9; ex_result = 32'h99;
    tick();
    idle_inputs();
    rs = 9; uses_rs = 1; data_in1 = 32'h33;
    #1;
    checks++; if (data_out1 !== 32'h33) begin errors++; $display("FAIL flush_no_fwd_s1: got %h want %h", data_out1, 32'h33); end
    tick();
    #1;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL flush_wb_we: got %b want 0", wb_we); end
    checks++; if (data_out1 !== 32'h33) begin errors++; $display("FAIL flush_no_fwd_s2: got %h want %h", data_out1, 32'h33); end
    checks++; if (fwd_count !== 16'd0) begin errors++; $display("FAIL flush_fwd_count: got %0d want 0", fwd_count); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_dest = 7; ex_result = 32'h300;
    tick();
    idle_inputs();
    rs = 7; uses_rs = 1; data_in1 = 32'h5A;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midstall_pre: got %b want 1", stall); end
    reset_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midstall_async_clear: got %b want 0", stall); end
    checks++; if (data_out1 !== 32'h5A) begin errors++; $display("FAIL midstall_out1: got %h want %h", data_out1, 32'h5A); end
    tick();
    reset_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    ex_valid = 1; ex_reg_write = 1; ex_dest = 1; ex_result = 32'h1234;
    rs = 1; uses_rs = 1;
    tick();
    tick();
    tick();
    checks++; if (fwd_count !== 16'd2) begin errors++; $display("FAIL sat_early_count: got %0d want 2", fwd_count); end
    for (int i = 0; i < 65545; i++) @(posedge clk);
    #1;
    checks++; if (fwd_count !== 16'hFFFF) begin errors++; $display("FAIL sat_fwd_count: got %h want %h", fwd_count, 16'hFFFF); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL sat_stall_count: got %0d want 0", stall_count); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_exmem_forward();
    test_priority();
    test_load_use();
    test_zero_and_unused();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the 5-stage MIPS pipeline.
- Sits between ID/EX and the ALU operand inputs.
- Internally holds the EX/MEM and MEM/WB destination/result slots and forwards their data to the ALU operands.
- Raises a load-use stall and drives the register-file write port from the WB slot.
- Keeps saturating performance counters for forwards and stalls.

Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  kill the instruction currently in EX; it enters the EX/MEM slot as a bubble
- ex_valid  in  1  EX-stage instruction is real, not a bubble
- ex_reg_write  in  1  EX instruction writes a register
- ex_mem_read  in  1  EX instruction is a load
- ex_dest  in  ADDR_W  EX instruction destination register
- ex_result  in  DATA_W  EX ALU result; this is the address for loads
- mem_load_data  in  DATA_W  data-memory read data for the instruction in the EX/MEM slot
- rs  in  ADDR_W  ID/EX source register 1
- rt  in  ADDR_W  ID/EX source register 2
- uses_rs  in  1  ID/EX instruction reads rs
- uses_rt  in  1  ID/EX instruction reads rt
- data_in1  in  DATA_W  register-file value for rs
- data_in2  in  DATA_W  register-file value for rt
- data_out1  out  DATA_W  ALU operand 1 after forwarding
- data_out2  out  DATA_W  ALU operand 2 after forwarding
- stall  out  1  load-use hazard; freeze PC, IF/ID and ID/EX
- wb_we  out  1  register-file write enable
- wb_addr  out  ADDR_W  register-file write address
- wb_data  out  DATA_W  register-file write data
- fwd_count  out  CNT_W  cycles in which at least one operand was forwarded
- stall_count  out  CNT_W  cycles with stall asserted

Behaviour:
Slots:
- S1 is EX/MEM and holds {v1, ld1, d1, r1}; S2 is MEM/WB and holds {v2, d2, r2}.
- Reset (reset_n low, asynchronous): v1, ld1, v2 = 0; d1, d2, r1, r2 = 0; both counters = 0. Therefore wb_we = 0, stall = 0, and data_out = data_in.
- Each rising edge:
  - S2 <= {v1, d1, ld1 ? mem_load_data : r1}
  - S1 loading:
    - stall = 1 or flush = 1: S1 <= bubble (v1 = 0, ld1 = 0, d1 and r1 hold value).
    - Otherwise: v1 <= ex_valid & ex_reg_write; ld1 <= ex_valid & ex_mem_read & ex_reg_write; d1 <= ex_dest; r1 <= ex_result.
- Register 0 is never a valid destination. v1 and v2 are qualified with d != 0 when used for matching and for wb_we.
- wb_we = v2 & (d2 != 0); wb_addr = d2; wb_data = r2. These are registered outputs, so latency is 2 cycles from EX to writeback.

Forwarding (combinational, per operand; shown for rs/data_out1, identical for rt/data_out2):
- hit1 = uses_rs & v1 & (d1 == rs) & (rs != 0)
- hit2 = uses_rs & v2 & (d2 == rs) & (rs != 0)
- hit1 & !ld1: data_out1 = r1 (S1 has priority, being the youngest writer).
- else hit2 & !hit1: data_out1 = r2.
- else: data_out1 = data_in1. This covers the hit1 & ld1 case, where the value is stale and stall is asserted.
- The S2 forward also covers a register-file write and read in the same cycle. The register file is not required to be write-through.

Stall:
- stall = (uses_rs & v1 & ld1 & d1 == rs & rs != 0) | (same for rt), evaluated combinationally.
- Exactly one stall cycle per load-use: the bubble enters S1, the load moves to S2, and the next cycle forwards from S2.
- flush has no effect on stall computation but forces the bubble. stall and flush together: a single bubble.

Counters:
- fwd_count increments when either operand selects r1 or r2 and stall = 0.
- stall_count increments when stall = 1.
- Both saturate at all-ones; no wrap.

Simultaneous events:
- A consumer reading the same register on both operands forwards both.
- S1 and S2 holding the same destination: S1 wins.
- Reset mid-stall clears all state at once and deasserts stall asynchronously.

Test Plan:
1. Reset then idle:
   - Stimulus: reset_n low with data_in1 = 0x11, data_in2 = 0x22.
   - Required: data_out = 0x11/0x22; wb_we = 0; stall = 0; counters = 0.
2. EX/MEM forward:
   - Stimulus: ALU op writes $3 = 0x0000_00AA; next cycle consumer rs = 3, uses_rs = 1.
   - Required: data_out1 = 0xAA; fwd_count = 1; two cycles after the producer's EX, wb_we = 1, wb_addr = 3, wb_data = 0xAA.
3. Priority:
   - Stimulus: $5 written with 0x1 then 0x2 on consecutive instructions; consumer reads rt = 5.
   - Required: data_out2 = 0x2.
4. Load-use:
   - Stimulus: load to $7 with mem_load_data = 0xDEAD_BEEF; next instruction uses rs = 7.
   - Required: stall = 1 for exactly one cycle, stall_count = 1; next cycle data_out1 = 0xDEADBEEF and stall = 0.
5. $0 and unused operands:
   - Stimulus: producer writes $0 = 0x55; consumer rs = 0. Separately, a load to $4 with consumer rt = 4 but uses_rt = 0.
   - Required: no forward; no stall; wb_we = 0 for the $0 write.
6. Flush and saturation:
   - Stimulus: flush with ex_valid = 1 writing $9; then force fwd_count to all-ones via a long forward stream.
   - Required: no write to $9 and no forward from it; fwd_count holds at 0xFFFF.
